eee_pattern_gen: RTL and testbench

Avalon-ST video test-pattern source for the vision pipeline. Produces 24-bit RGB frames, each framed by startofpacket/endofpacket, and feeds the sink port of the edge-detect/image-processing filter. The generator exercises that filter without the camera path. A 3-bit-address Avalon-MM slave selects the pattern, frame size and enable, and exposes a frame counter.

---
 rtl/eee_pattern_gen_if.sv | 29 ++
 rtl/eee_pattern_gen.sv | 182 ++++++++++++++++++
 tb/tb_eee_pattern_gen.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eee_pattern_gen_if.sv
// Avalon-ST video source plus Avalon-MM control slave bundle
// for the test-pattern generator.
interface eee_pattern_gen_if;
    logic [23:0] source_data;
    logic        source_valid;
    logic        source_ready;
    logic        source_sop;
    logic        source_eop;
    logic        s_chipselect;
    logic        s_read;
    logic        s_write;
    logic [2:0]  s_address;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;

    modport master (
        output source_data, source_valid, source_sop, source_eop,
        input  source_ready,
        input  s_chipselect, s_read, s_write, s_address, s_writedata,
        output s_readdata
    );

    modport slave (
        input  source_data, source_valid, source_sop, source_eop,
        output source_ready,
        output s_chipselect, s_read, s_write, s_address, s_writedata,
        input  s_readdata
    );
endinterface

// File: rtl/eee_pattern_gen.sv
// Avalon-ST RGB test-pattern source (bars, gradient, checker, solid)
// with a small Avalon-MM register block and completed-frame counter.
module eee_pattern_gen #(
    parameter int          DEF_WIDTH  = 640,
    parameter int          DEF_HEIGHT = 480,
    parameter logic [31:0] ID_VALUE   = 32'h5047_0001
) (
    input logic              clk,
    input logic              reset,
    eee_pattern_gen_if.master bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HEADER = 2'd1;
    localparam logic [1:0] S_PIXELS = 2'd2;

    logic [1:0]  state;
    logic        enable;
    logic [1:0]  pattern;
    logic [11:0] width, height;
    logic [23:0] colour;
    logic [31:0] frames;
    logic [11:0] sw, sh;
    logic [1:0]  spat;
    logic [11:0] x, y, bcnt;
    logic [2:0]  bar;
    logic        valid, sop, eop;
    logic [23:0] data;
    logic [31:0] rd_mux;

    logic        xfer, wr_en, frames_clr;
    logic [11:0] lw, lh, bw;
    logic [11:0] nx, ny, nbcnt;
    logic [2:0]  nbar;
    logic        next_eop;
    logic [23:0] pix;

    assign xfer       = valid && bus.source_ready;
    assign wr_en      = bus.s_chipselect && bus.s_write;
    assign frames_clr = wr_en && (bus.s_address == 3'd4);
    assign lw         = (width == 12'd0) ? 12'd1 : width;
    assign lh         = (height == 12'd0) ? 12'd1 : height;
    assign bw         = (sw[11:3] == 9'd0) ? 12'd1 : {3'd0, sw[11:3]};

    // Coordinates of the beat that will be presented after the next transfer
    always_comb begin
        nx    = x;
        ny    = y;
        nbar  = bar;
        nbcnt = bcnt;
        if (state == S_HEADER) begin
            nx    = 12'd0;
            ny    = 12'd0;
            nbar  = 3'd0;
            nbcnt = 12'd0;
        end else if (x == sw - 12'd1) begin
            nx    = 12'd0;
            ny    = y + 12'd1;
            nbar  = 3'd0;
            nbcnt = 12'd0;
        end else begin
            nx = x + 12'd1;
            if (bcnt == bw - 12'd1) begin
                nbcnt = 12'd0;
                if (bar != 3'd7) nbar = bar + 3'd1;
            end else begin
                nbcnt = bcnt + 12'd1;
            end
        end
    end

    assign next_eop = (nx == sw - 12'd1) && (ny == sh - 12'd1);

    // Bar index bits map straight onto the R/G/B on-off pattern
    always_comb begin
        unique case (spat)
            2'd0:    pix = {{8{~nbar[1]}}, {8{~nbar[2]}}, {8{~nbar[0]}}};
            2'd1:    pix = {nx[7:0], ny[7:0], frames[7:0]};
            2'd2:    pix = (nx[4] ^ ny[4]) ? 24'hFFFFFF : 24'h000000;
            default: pix = colour;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        unique case (bus.s_address)
            3'd0:    rd_mux = {29'd0, pattern, enable};
            3'd1:    rd_mux = {20'd0, width};
            3'd2:    rd_mux = {20'd0, height};
            3'd3:    rd_mux = {8'd0, colour};
            3'd4:    rd_mux = frames;
            3'd5:    rd_mux = ID_VALUE;
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            enable         <= 1'b0;
            pattern        <= 2'd0;
            width          <= 12'(DEF_WIDTH);
            height         <= 12'(DEF_HEIGHT);
            colour         <= 24'd0;
            frames         <= 32'd0;
            sw             <= 12'd1;
            sh             <= 12'd1;
            spat           <= 2'd0;
            x              <= 12'd0;
            y              <= 12'd0;
            bcnt           <= 12'd0;
            bar            <= 3'd0;
            valid          <= 1'b0;
            sop            <= 1'b0;
            eop            <= 1'b0;
            data           <= 24'd0;
            bus.s_readdata <= 32'd0;
        end else begin
            if (wr_en) begin
                case (bus.s_address)
                    3'd0: {pattern, enable} <= bus.s_writedata[2:0];
                    3'd1: width  <= bus.s_writedata[11:0];
                    3'd2: height <= bus.s_writedata[11:0];
                    3'd3: colour <= bus.s_writedata[23:0];
                    default: ;
                endcase
            end
            if (bus.s_chipselect && bus.s_read)
                bus.s_readdata <= rd_mux;
            // A clear on the eop cycle beats the increment
            if (frames_clr)
                frames <= 32'd0;
            else if (xfer && eop)
                frames <= frames + 32'd1;

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_HEADER;
                        sw    <= lw;
                        sh    <= lh;
                        spat  <= pattern;
                        valid <= 1'b1;
                        sop   <= 1'b1;
                        eop   <= 1'b0;
                        data  <= 24'd0;
                    end
                end
                S_HEADER, S_PIXELS: begin
                    if (xfer && eop) begin
                        sop  <= enable;
                        eop  <= 1'b0;
                        data <= 24'd0;
                        if (enable) begin
                            state <= S_HEADER;
                            sw    <= lw;
                            sh    <= lh;
                            spat  <= pattern;
                        end else begin
                            state <= S_IDLE;
                            valid <= 1'b0;
                        end
                    end else if (xfer) begin
                        state <= S_PIXELS;
                        x     <= nx;
                        y     <= ny;
                        bar   <= nbar;
                        bcnt  <= nbcnt;
                        sop   <= 1'b0;
                        eop   <= next_eop;
                        data  <= pix;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.source_valid = valid;
    assign bus.source_sop   = sop;
    assign bus.source_eop   = eop;
    assign bus.source_data  = data;
endmodule

// File: tb/tb_eee_pattern_gen.sv
// Bench for eee_pattern_gen: register table, directed frame sequences
// and random frames checked against an arithmetic pattern model.
module tb_eee_pattern_gen;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    eee_pattern_gen_if bus ();
    eee_pattern_gen dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [23:0] d;
        logic        s;
        logic        e;
    } beat_t;

    typedef struct {
        bit          do_wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    int total = 0;
    int bad = 0;
    int frames_exp = 0;
    beat_t got[$];
    beat_t exp_q[$];
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.s_chipselect = 1'b1;
        bus.s_write = 1'b1;
        bus.s_address = a;
        bus.s_writedata = d;
        @(posedge clk); #1;
        bus.s_chipselect = 1'b0;
        bus.s_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.s_chipselect = 1'b1;
        bus.s_read = 1'b1;
        bus.s_address = a;
        @(posedge clk); #1;
        bus.s_chipselect = 1'b0;
        bus.s_read = 1'b0;
        d = bus.s_readdata;
    endtask

    function automatic logic [23:0] ref_pix(input int x, input int y, input int w,
                                            input int pat, input logic [23:0] col,
                                            input logic [31:0] fr);
        int bw;
        int idx;
        bw = (w / 8 < 1) ? 1 : w / 8;
        idx = x / bw;
        if (idx > 7) idx = 7;
        case (pat)
            0: return bar_tab[idx];
            1: return {x[7:0], y[7:0], fr[7:0]};
            2: return (x[4] ^ y[4]) ? 24'hFFFFFF : 24'h000000;
            default: return col;
        endcase
    endfunction

    task automatic build(input int w, input int h, input int pat,
                         input logic [23:0] col, input logic [31:0] fr);
        exp_q.delete();
        if (w == 0) w = 1;
        if (h == 0) h = 1;
        exp_q.push_back('{24'h0, 1'b1, 1'b0});
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                exp_q.push_back('{ref_pix(xx, yy, w, pat, col, fr), 1'b0,
                                  (xx == w - 1) && (yy == h - 1)});
    endtask

    task automatic capture(input int max_beats, input bit rnd, output int cycles);
        int n;
        bit done;
        logic v;
        beat_t b;
        n = 0;
        done = 0;
        cycles = 0;
        for (int c = 0; c < 4000 && !done; c++) begin
            bus.source_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            v = bus.source_valid;
            b = {bus.source_data, bus.source_sop, bus.source_eop};
            @(posedge clk); #1;
            cycles++;
            if (v && bus.source_ready) begin
                got.push_back(b);
                n++;
                if (b.e || n == max_beats) done = 1;
            end else if (v) begin
                chk("hold", {5'd0, bus.source_valid, bus.source_data,
                             bus.source_sop, bus.source_eop}, {5'd0, 1'b1, b});
            end
        end
        bus.source_ready = 1'b0;
        if (!done) chk("capture_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare(input string name);
        chk({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_beat%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    reg_vec_t tab [14];
    logic [31:0] v;
    int cyc;
    int seen;

    initial begin
        tab[0]  = '{0, 3'd5, 32'h0,         32'h50470001};
        tab[1]  = '{0, 3'd4, 32'h0,         32'h0};
        tab[2]  = '{0, 3'd1, 32'h0,         32'd640};
        tab[3]  = '{0, 3'd2, 32'h0,         32'd480};
        tab[4]  = '{0, 3'd0, 32'h0,         32'h0};
        tab[5]  = '{0, 3'd3, 32'h0,         32'h0};
        tab[6]  = '{1, 3'd3, 32'hFFABCDEF,  32'h00ABCDEF};
        tab[7]  = '{1, 3'd1, 32'hFFFFF123,  32'h123};
        tab[8]  = '{1, 3'd0, 32'hFFFFFFF6,  32'h6};
        tab[9]  = '{1, 3'd6, 32'h1234,      32'h0};
        tab[10] = '{1, 3'd5, 32'h0,         32'h50470001};
        tab[11] = '{1, 3'd4, 32'h1,         32'h0};
        tab[12] = '{0, 3'd7, 32'h0,         32'h0};
        tab[13] = '{1, 3'd2, 32'h0,         32'h0};

        reset = 1'b1;
        bus.source_ready = 1'b0;
        bus.s_chipselect = 1'b0;
        bus.s_read = 1'b0;
        bus.s_write = 1'b0;
        bus.s_address = 3'd0;
        bus.s_writedata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stream", {5'd0, bus.source_valid, bus.source_data,
                           bus.source_sop, bus.source_eop}, 32'd0);
        chk("rst_readdata", bus.s_readdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (tab[i].do_wr) wr(tab[i].addr, tab[i].wdata);
            rd(tab[i].addr, v);
            chk($sformatf("reg%0d", i), v, tab[i].exp);
        end
        chk("reg_no_stream", {31'd0, bus.source_valid}, 32'd0);

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        frames_exp = 0;

        // 8x2 colour bars, ready high, enable-to-header latency
        wr(1, 8);
        wr(2, 2);
        wr(0, 1);
        chk("hdr_not_yet", {31'd0, bus.source_valid}, 32'd0);
        @(posedge clk); #1;
        chk("hdr_latency", {30'd0, bus.source_valid, bus.source_sop}, 32'd3);
        build(8, 2, 0, 24'h0, frames_exp);
        got.delete();
        capture(0, 0, cyc);
        frames_exp++;
        compare("bars");
        chk("bars_cycles", cyc, 17);
        chk("b2b_header", {30'd0, bus.source_valid, bus.source_sop}, 32'd3);

        got.delete();
        capture(0, 1, cyc);
        frames_exp++;
        compare("bars_stall");
        rd(4, v);
        chk("frames_two", v, frames_exp);

        // Disable while a header waits: that frame still completes
        wr(0, 0);
        got.delete();
        capture(0, 0, cyc);
        frames_exp++;
        compare("bars_drain");
        chk("idle_after_drain", {31'd0, bus.source_valid}, 32'd0);

        // Solid 4x1, enable cleared after two beats
        wr(3, 32'h123456);
        wr(1, 4);
        wr(2, 1);
        wr(0, 7);
        build(4, 1, 3, 24'h123456, frames_exp);
        got.delete();
        capture(2, 0, cyc);
        wr(0, 6);
        capture(0, 0, cyc);
        frames_exp++;
        compare("solid");
        chk("solid_idle", {31'd0, bus.source_valid}, 32'd0);
        bus.source_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("solid_stay_idle", {31'd0, bus.source_valid}, 32'd0);
        bus.source_ready = 1'b0;

        // Zero size latches as 1x1
        wr(1, 0);
        wr(2, 0);
        wr(0, 1);
        for (int k = 0; k < 3; k++) begin
            build(0, 0, 0, 24'h0, frames_exp);
            got.delete();
            capture(0, 0, cyc);
            frames_exp++;
            compare($sformatf("one_px%0d", k));
            if (k > 0) chk($sformatf("one_px_cycles%0d", k), cyc, 2);
        end
        rd(4, v);
        chk("frames_one_px", v, frames_exp);
        bus.source_ready = 1'b1;
        @(posedge clk); #1;
        chk("eop_pending", {31'd0, bus.source_eop}, 32'd1);
        bus.s_chipselect = 1'b1;
        bus.s_write = 1'b1;
        bus.s_address = 3'd4;
        bus.s_writedata = 32'h55;
        @(posedge clk); #1;
        bus.s_chipselect = 1'b0;
        bus.s_write = 1'b0;
        bus.source_ready = 1'b0;
        rd(4, v);
        chk("frames_clr_on_eop", v, 32'd0);
        frames_exp = 0;
        wr(0, 0);
        got.delete();
        capture(0, 0, cyc);
        frames_exp++;
        chk("one_px_idle", {31'd0, bus.source_valid}, 32'd0);

        // Random single frames against the model
        for (int it = 0; it < 8; it++) begin
            int w, h, pat;
            logic [23:0] col;
            w = $urandom_range(1, 20);
            h = $urandom_range(1, 4);
            pat = $urandom_range(0, 3);
            col = 24'($urandom);
            wr(1, w);
            wr(2, h);
            wr(3, {8'd0, col});
            wr(0, {29'd0, pat[1:0], 1'b1});
            wr(0, {29'd0, pat[1:0], 1'b0});
            build(w, h, pat, col, frames_exp);
            got.delete();
            capture(0, 1, cyc);
            frames_exp++;
            compare($sformatf("rand%0d", it));
            chk($sformatf("rand%0d_idle", it), {31'd0, bus.source_valid}, 32'd0);
        end
        rd(4, v);
        chk("frames_rand", v, frames_exp);

        // Reset in the middle of a 640x480 gradient frame
        wr(1, 640);
        wr(2, 480);
        wr(0, 3);
        bus.source_ready = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("big_running", {31'd0, bus.source_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_stream", {5'd0, bus.source_valid, bus.source_data,
                               bus.source_sop, bus.source_eop}, 32'd0);
        reset = 1'b0;
        rd(0, v);
        chk("mid_rst_ctrl", v, 32'd0);
        seen = 0;
        bus.source_ready = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.source_valid) seen++;
        end
        chk("mid_rst_quiet", seen, 0);
        rd(1, v);
        chk("mid_rst_width", v, 32'd640);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
